// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler.
//   ch_state_e : per-channel state; bit0 = counting (ARMED), bit1 = event pending (PEND).
//                ST_ARMED_PEND only occurs for periodic channels (TICK_SCHED_RELOAD_EN).
//   NCH_DEF/DW_DEF : default channel count and countdown width.
//   clog2      : ceiling log2, minimum 1, used for the event id width.
package tick_sched_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned DW_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_ARMED      = 2'b01,
    ST_PEND       = 2'b10,
    ST_ARMED_PEND = 2'b11
  } ch_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) wins.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted request (zero when no request)
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic          found;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate so that ptr sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = found ? IW'(sum) : '0;
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      gnt[k] = found && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel one-shot/periodic timeout scheduler sharing one tick timer.
//   clk, rst      : clock and synchronous active-high reset
//   req_valid/len : per-channel arm request and timeout in ticks (len 0 = expire at once)
//   req_periodic  : reload on expiry (only with TICK_SCHED_RELOAD_EN)
//   req_ready     : combinational one-hot arm grant
//   cancel        : per-channel abort, drops any pending event
//   tick/tick_en  : timer wrap pulse in, timer enable out (high while any channel counts)
//   busy          : channel not idle
//   evt_*         : expiry events, one at a time, valid/ready
//   overrun       : sticky, periodic expiry while previous event undelivered
// Optional feature macro: TICK_SCHED_RELOAD_EN (periodic reload, overrun flags).
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned IW  = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_len,
  input  logic [NCH-1:0]    req_periodic,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH-1:0]    cancel,
  input  logic              tick,
  output logic              tick_en,
  output logic [NCH-1:0]    busy,
  output logic              evt_valid,
  output logic [IW-1:0]     evt_id,
  input  logic              evt_ready,
  output logic [NCH-1:0]    overrun
);

  logic [NCH-1:0] armed_q, pend_q, armed_d, idle_d;
  logic [NCH-1:0] arm_req, arm_gnt, ev_gnt_unused;
  logic [IW-1:0]  arm_idx, arm_ptr_q, ev_idx, ev_ptr_q, lock_id_q;
  logic           locked_q, hs;

  // Arm acceptance: a cancel in the same cycle blocks the request.
  assign arm_req   = req_valid & ~(armed_q | pend_q) & ~cancel;
  assign req_ready = arm_gnt;

  rr_arb #(.N(NCH), .IW(IW)) u_arm_arb (
    .req (arm_req),
    .ptr (arm_ptr_q),
    .gnt (arm_gnt),
    .idx (arm_idx)
  );

  rr_arb #(.N(NCH), .IW(IW)) u_evt_arb (
    .req (pend_q),
    .ptr (ev_ptr_q),
    .gnt (ev_gnt_unused),
    .idx (ev_idx)
  );

  // Once presented, the event choice holds until handshake or cancel of that channel.
  assign evt_valid = |pend_q;
  assign evt_id    = locked_q ? lock_id_q : ev_idx;
  assign hs        = evt_valid & evt_ready;

  // Shared pointers, event lock and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_ptr_q <= '0;
      ev_ptr_q  <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
      tick_en   <= 1'b0;
      busy      <= '0;
    end else begin
      if (|arm_gnt) begin
        arm_ptr_q <= (arm_idx == IW'(NCH-1)) ? '0 : arm_idx + IW'(1);
      end
      if (evt_valid && (evt_ready || cancel[evt_id])) begin
        locked_q <= 1'b0;
        if (evt_ready) ev_ptr_q <= (evt_id == IW'(NCH-1)) ? '0 : evt_id + IW'(1);
      end else if (evt_valid) begin
        locked_q  <= 1'b1;
        lock_id_q <= evt_id;
      end
      tick_en <= |armed_d;
      busy    <= ~idle_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e     st_q, st_d;
    logic [DW-1:0] cnt_q, cnt_d, len_v;
    logic          armed_v, pend_v, hs_i;
`ifdef TICK_SCHED_RELOAD_EN
    logic          per_q, per_d, ovr_q, ovr_d;
    logic [DW-1:0] rld_q, rld_d;
`endif

    assign hs_i = hs && (evt_id == IW'(i));

    // Channel next state: arm, count, expire, deliver, cancel.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      len_v   = req_len[i*DW +: DW];
      armed_v = (st_q == ST_ARMED) || (st_q == ST_ARMED_PEND);
      pend_v  = (st_q == ST_PEND)  || (st_q == ST_ARMED_PEND);
`ifdef TICK_SCHED_RELOAD_EN
      per_d   = per_q;
      rld_d   = rld_q;
      ovr_d   = ovr_q;
`endif
      if (st_q == ST_IDLE) begin
        if (arm_gnt[i]) begin
`ifdef TICK_SCHED_RELOAD_EN
          per_d = req_periodic[i];
          if (req_periodic[i] && (len_v == '0)) len_v = DW'(1);
          rld_d = len_v;
`endif
          cnt_d = len_v;
          st_d  = (len_v == '0) ? ST_PEND : ST_ARMED;
        end
      end else begin
        // Delivery retires the old event before a same-cycle expiry raises a new one.
        pend_v = pend_v && !hs_i;
        if (armed_v && tick && tick_en) begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) begin
`ifdef TICK_SCHED_RELOAD_EN
            if (per_q) begin
              if (pend_v) ovr_d = 1'b1;
              cnt_d = rld_q;
            end else begin
              armed_v = 1'b0;
            end
`else
            armed_v = 1'b0;
`endif
            pend_v = 1'b1;
          end
        end
        if (cancel[i]) begin
          armed_v = 1'b0;
          pend_v  = 1'b0;
        end
        st_d = ch_state_e'({pend_v, armed_v});
      end
`ifdef TICK_SCHED_RELOAD_EN
      if (cancel[i]) ovr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
`ifdef TICK_SCHED_RELOAD_EN
        per_q <= 1'b0;
        rld_q <= '0;
        ovr_q <= 1'b0;
`endif
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
`ifdef TICK_SCHED_RELOAD_EN
        per_q <= per_d;
        rld_q <= rld_d;
        ovr_q <= ovr_d;
`endif
      end
    end

    assign armed_q[i] = (st_q == ST_ARMED) || (st_q == ST_ARMED_PEND);
    assign pend_q[i]  = (st_q == ST_PEND)  || (st_q == ST_ARMED_PEND);
    assign armed_d[i] = (st_d == ST_ARMED) || (st_d == ST_ARMED_PEND);
    assign idle_d[i]  = (st_d == ST_IDLE);
`ifdef TICK_SCHED_RELOAD_EN
    assign overrun[i] = ovr_q;
`endif
  end

`ifndef TICK_SCHED_RELOAD_EN
  logic unused_periodic;
  assign unused_periodic = ^req_periodic;
  assign overrun         = '0;
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched (NCH=4, DW=16). Expected event ids are queued by the
// stimulus; a negedge monitor pops and compares on every handshake.
module tb_tick_sched;

  logic        clk, rst;
  logic [3:0]  req_valid, req_periodic, req_ready, cancel, busy, overrun;
  logic [63:0] req_len;
  logic        tick, tick_en, evt_valid, evt_ready;
  logic [1:0]  evt_id, exp_id;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  tick_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_periodic (req_periodic),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .tick         (tick),
    .tick_en      (tick_en),
    .busy         (busy),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every handshake must match the next expected id.
  always @(negedge clk) begin
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got id %0d, required no event", evt_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (evt_id !== exp_id) begin
          errors++;
          $display("FAIL evt_id_order: got %0d, required %0d", evt_id, exp_id);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    cancel       = '0;
    tick         = 1'b0;
    req_periodic = '0;
    nxt();
    rst = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
  endtask

  task automatic arm(input int ch, input int len);
    req_valid           = 4'(1 << ch);
    req_len[ch*16 +: 16] = 16'(len);
    #1;
    chk("arm_ready", 32'(req_ready), 32'(1 << ch));
    nxt();
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_len = '0; req_periodic = '0;
    cancel = '0; tick = 1'b0; evt_ready = 1'b1;
    do_reset();
    #1;
    chk("rst_busy",    32'(busy),      32'h0);
    chk("rst_tick_en", 32'(tick_en),   32'h0);
    chk("rst_evt_val", 32'(evt_valid), 32'h0);
    chk("rst_evt_id",  32'(evt_id),    32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    chk("rst_ready",   32'(req_ready), 32'h0);

    // 1: ch0 len 3, tick every 4 cycles
    arm(0, 3);
    chk("t1_busy",    32'(busy),    32'h1);
    chk("t1_tick_en", 32'(tick_en), 32'h1);
    exp_q.push_back(2'd0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) nxt();
      do_tick();
      if (k == 2) chk("t1_no_evt_early", 32'(evt_valid), 32'h0);
    end
    chk("t1_evt_valid",   32'(evt_valid), 32'h1);
    chk("t1_evt_id",      32'(evt_id),    32'h0);
    chk("t1_tick_en_off", 32'(tick_en),   32'h0);
    nxt();
    chk("t1_idle", 32'(busy), 32'h0);

    // 2: all four request at once, len 0, granted in order 0..3
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'(4'hF << k);
      req_len[k*16 +: 16] = 16'd0;
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1 << k));
      nxt();
    end
    req_valid = '0;
    repeat (3) nxt();
    chk("t2_drained", 32'(busy), 32'h0);

    // 3: ch1, ch2 expire together; stalled id must hold at 1
    do_reset();
    req_len[16 +: 16] = 16'd2;
    req_len[32 +: 16] = 16'd2;
    req_valid = 4'b0110;
    #1; chk("t3_grant1", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 4'b0100;
    #1; chk("t3_grant2", 32'(req_ready), 32'h4);
    nxt();
    req_valid = '0;
    evt_ready = 1'b0;
    do_tick();
    do_tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_id", 32'(evt_id), 32'h1);
      nxt();
    end
    chk("t3_stall_valid", 32'(evt_valid), 32'h1);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    evt_ready = 1'b1;
    repeat (4) nxt();
    chk("t3_drained", 32'(evt_valid), 32'h0);

    // 4: cancel while counting, then cancel a pending event
    do_reset();
    arm(3, 5);
    do_tick();
    do_tick();
    cancel = 4'b1000;
    nxt();
    cancel = '0;
    chk("t4_busy3",    32'(busy),    32'h0);
    chk("t4_tick_en",  32'(tick_en), 32'h0);
    repeat (5) do_tick();
    chk("t4_no_evt", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;
    arm(0, 0);
    chk("t4_pend", 32'(evt_valid), 32'h1);
    cancel = 4'b0001;
    nxt();
    cancel = '0;
    chk("t4_dropped", 32'(evt_valid), 32'h0);
    chk("t4_idle",    32'(busy),      32'h0);
    evt_ready = 1'b1;
    nxt();

    // 5: len 0 with no tick, then reset with an event in flight
    do_reset();
    exp_q.push_back(2'd2);
    arm(2, 0);
    chk("t5_valid", 32'(evt_valid), 32'h1);
    chk("t5_id",    32'(evt_id),    32'h2);
    nxt();
    arm(1, 10);
    do_tick();
    evt_ready = 1'b0;
    arm(0, 0);
    chk("t5_inflight", 32'(evt_valid), 32'h1);
    do_reset();
    #1;
    chk("t5_busy",    32'(busy),      32'h0);
    chk("t5_tick_en", 32'(tick_en),   32'h0);
    chk("t5_valid0",  32'(evt_valid), 32'h0);
    chk("t5_id0",     32'(evt_id),    32'h0);
    chk("t5_overrun", 32'(overrun),   32'h0);
    req_valid = 4'hF;
    #1;
    chk("t5_ptr_reset", 32'(req_ready), 32'h1);
    req_valid = '0;
    evt_ready = 1'b1;
    nxt();

    // 6: periodic ch0 len 2 with the consumer stalled
    do_reset();
    evt_ready    = 1'b0;
    req_periodic = 4'b0001;
    arm(0, 2);
    req_periodic = '0;
    do_tick();
    do_tick();
    chk("t6_evt1", 32'(evt_valid), 32'h1);
    chk("t6_no_ovr_yet", 32'(overrun), 32'h0);
    do_tick();
    do_tick();
`ifdef TICK_SCHED_RELOAD_EN
    chk("t6_overrun", 32'(overrun), 32'h1);
    chk("t6_tick_en", 32'(tick_en), 32'h1);
`else
    chk("t6_overrun", 32'(overrun), 32'h0);
    chk("t6_tick_en", 32'(tick_en), 32'h0);
`endif
    exp_q.push_back(2'd0);
    evt_ready = 1'b1;
    nxt();
`ifdef TICK_SCHED_RELOAD_EN
    exp_q.push_back(2'd0);
`endif
    do_tick();
    do_tick();
    nxt();
`ifdef TICK_SCHED_RELOAD_EN
    chk("t6_still_busy", 32'(busy), 32'h1);
`else
    chk("t6_still_busy", 32'(busy), 32'h0);
`endif
    cancel = 4'b0001;
    nxt();
    cancel = '0;
    chk("t6_ovr_clear", 32'(overrun), 32'h0);
    chk("t6_idle",      32'(busy),    32'h0);
    repeat (3) nxt();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
